id_ex_stage: RTL

//  ID/EX pipeline register plus operand forwarding for the execute stage; sits directly upstream of the ALU.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/operand_forward.sv | 47 ++++
 rtl/id_ex_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
//  Shared CPU definitions for the execute-side pipeline blocks.
//  - Datapath widths (XLEN, RW) and the control bundle width (CTRL_W).
//  - ALU operation selects driven on ctrl[2:0].
//  - Bit positions of each field inside the control bundle:
//      {jump,branch,mem_wen,mem_ren,rd_wen,op2_imm,op1_pc,arith,unsigned,sub,opsel[2:0]}
//  - A helper that recognises a register-writing load in a control bundle.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int RW     = 5;
  localparam int CTRL_W = 13;

  // ALU operation selects
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // Control bundle bit indices
  localparam int CTRL_OPSEL_LSB = 0;
  localparam int CTRL_OPSEL_MSB = 2;
  localparam int CTRL_SUB       = 3;
  localparam int CTRL_UNSIGNED  = 4;
  localparam int CTRL_ARITH     = 5;
  localparam int CTRL_OP1_PC    = 6;
  localparam int CTRL_OP2_IMM   = 7;
  localparam int CTRL_RD_WEN    = 8;
  localparam int CTRL_MEM_REN   = 9;
  localparam int CTRL_MEM_WEN   = 10;
  localparam int CTRL_BRANCH    = 11;
  localparam int CTRL_JUMP      = 12;

  // A load whose result lands in the register file; only these can cause
  // a load-use hazard because their data is not ready until MEM.
  function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_REN] & ctrl[CTRL_RD_WEN];
  endfunction

endpackage

// File: rtl/operand_forward.sv
// operand_forward
//  Selects the freshest value of one source register for the execute stage.
//  Ports:
//   rs_addr     in   RW    source register address (registered in ID/EX)
//   rf_data     in   XLEN  register-file value captured with the instruction
//   exmem_rd    in   RW    EX/MEM destination register
//   exmem_wen   in   1     EX/MEM writes a register
//   exmem_data  in   XLEN  EX/MEM result
//   memwb_rd    in   RW    MEM/WB destination register
//   memwb_wen   in   1     MEM/WB writes a register
//   memwb_data  in   XLEN  MEM/WB writeback data
//   fwd_data    out  XLEN  forwarded operand value
module operand_forward #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int RW   = cpu_pkg::RW
) (
  input  logic [RW-1:0]   rs_addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic [RW-1:0]   exmem_rd,
  input  logic            exmem_wen,
  input  logic [XLEN-1:0] exmem_data,
  input  logic [RW-1:0]   memwb_rd,
  input  logic            memwb_wen,
  input  logic [XLEN-1:0] memwb_data,
  output logic [XLEN-1:0] fwd_data
);

  logic exmem_hit;
  logic memwb_hit;

  always_comb begin
    exmem_hit = exmem_wen && (exmem_rd == rs_addr) && (exmem_rd != '0);
    memwb_hit = memwb_wen && (memwb_rd == rs_addr) && (memwb_rd != '0);
    fwd_data  = rf_data;
    // x0 is hard-wired: never take the register-file value or a forward,
    // even if an upstream stage claims to write x0.
    if (rs_addr == '0) begin
      fwd_data = '0;
    end else if (exmem_hit) begin
      // EX/MEM holds the younger producer, so it beats MEM/WB.
      fwd_data = exmem_data;
    end else if (memwb_hit) begin
      fwd_data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//  ID/EX pipeline register with operand forwarding and load-use detection.
//  Captures the decoded instruction, resolves RAW hazards by forwarding from
//  EX/MEM and MEM/WB, builds the two ALU operands and the store data, and
//  raises o_load_use when the instruction in decode needs a load result that
//  is still in EX (a bubble is then captured for one cycle).
//  Ports:
//   i_clk, i_rst_n             clock (rising edge), async active-low reset
//   i_stall                    hold all stage registers
//   i_flush                    capture a bubble instead of the decode slot
//   i_valid, i_pc              decode slot valid and PC
//   i_rs1_data, i_rs2_data     register-file read data
//   i_imm                      sign-extended immediate
//   i_rs1_addr, i_rs2_addr     source register addresses
//   i_rd_addr                  destination register address
//   i_uses_rs1, i_uses_rs2     instruction actually reads rs1 / rs2
//   i_ctrl                     decoded control bundle (layout in cpu_pkg)
//   i_exmem_*                  EX/MEM forward port (rd, wen, data)
//   i_memwb_*                  MEM/WB forward port (rd, wen, data)
//   o_valid, o_pc, o_ctrl      registered slot valid, PC, control
//   o_rd_addr                  registered destination register
//   o_op1, o_op2               ALU operands
//   o_store_data               forwarded rs2 value for stores
//   o_load_use                 load-use hazard, upstream must hold IF/ID
module id_ex_stage #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int RW     = cpu_pkg::RW,
  parameter int CTRL_W = cpu_pkg::CTRL_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [XLEN-1:0]   i_rs2_data,
  input  logic [XLEN-1:0]   i_imm,
  input  logic [RW-1:0]     i_rs1_addr,
  input  logic [RW-1:0]     i_rs2_addr,
  input  logic [RW-1:0]     i_rd_addr,
  input  logic              i_uses_rs1,
  input  logic              i_uses_rs2,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [RW-1:0]     i_exmem_rd,
  input  logic              i_exmem_wen,
  input  logic [XLEN-1:0]   i_exmem_data,
  input  logic [RW-1:0]     i_memwb_rd,
  input  logic              i_memwb_wen,
  input  logic [XLEN-1:0]   i_memwb_data,
  output logic              o_valid,
  output logic [XLEN-1:0]   o_pc,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [RW-1:0]     o_rd_addr,
  output logic [XLEN-1:0]   o_op1,
  output logic [XLEN-1:0]   o_op2,
  output logic [XLEN-1:0]   o_store_data,
  output logic              o_load_use
);

  import cpu_pkg::*;

  // Stage registers
  logic              valid_q,    valid_d;
  logic [XLEN-1:0]   pc_q,       pc_d;
  logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
  logic [RW-1:0]     rd_addr_q,  rd_addr_d;
  logic [RW-1:0]     rs1_addr_q, rs1_addr_d;
  logic [RW-1:0]     rs2_addr_q, rs2_addr_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q,      imm_d;

  logic              load_use;

  // ---------------------------------------------------------------------
  // Load-use detection: the instruction in EX is a load writing a real
  // register that the decode-slot instruction reads. Looks at the live
  // decode inputs, so it is purely combinational. Suppressed on flush
  // because the decode slot is being discarded anyway.
  // ---------------------------------------------------------------------
  always_comb begin
    load_use = 1'b0;
    if (!i_flush && valid_q && ctrl_is_load(ctrl_q) &&
        (rd_addr_q != '0) && i_valid) begin
      load_use = (i_uses_rs1 && (i_rs1_addr == rd_addr_q)) ||
                 (i_uses_rs2 && (i_rs2_addr == rd_addr_q));
    end
  end

  // ---------------------------------------------------------------------
  // Next-state selection: flush > stall > load-use bubble > capture.
  // ---------------------------------------------------------------------
  always_comb begin
    // default: hold
    valid_d    = valid_q;
    pc_d       = pc_q;
    ctrl_d     = ctrl_q;
    rd_addr_d  = rd_addr_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;

    if (i_flush || (!i_stall && load_use)) begin
      // Bubble: zero control means no register, memory or PC side effects.
      valid_d    = 1'b0;
      pc_d       = '0;
      ctrl_d     = '0;
      rd_addr_d  = '0;
      rs1_addr_d = '0;
      rs2_addr_d = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
    end else if (!i_stall) begin
      valid_d    = i_valid;
      pc_d       = i_pc;
      // An empty decode slot must not carry live control into EX.
      ctrl_d     = i_valid ? i_ctrl : '0;
      rd_addr_d  = i_rd_addr;
      rs1_addr_d = i_rs1_addr;
      rs2_addr_d = i_rs2_addr;
      rs1_data_d = i_rs1_data;
      rs2_data_d = i_rs2_data;
      imm_d      = i_imm;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      ctrl_q     <= '0;
      rd_addr_q  <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      ctrl_q     <= ctrl_d;
      rd_addr_q  <= rd_addr_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
    end
  end

  // ---------------------------------------------------------------------
  // Forwarding: one resolver per source operand (index 0 = rs1, 1 = rs2).
  // ---------------------------------------------------------------------
  logic [RW-1:0]   fwd_rs_addr [2];
  logic [XLEN-1:0] fwd_rf_data [2];
  logic [XLEN-1:0] fwd_value   [2];

  assign fwd_rs_addr[0] = rs1_addr_q;
  assign fwd_rs_addr[1] = rs2_addr_q;
  assign fwd_rf_data[0] = rs1_data_q;
  assign fwd_rf_data[1] = rs2_data_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      operand_forward #(
        .XLEN (XLEN),
        .RW   (RW)
      ) u_operand_forward (
        .rs_addr    (fwd_rs_addr[gi]),
        .rf_data    (fwd_rf_data[gi]),
        .exmem_rd   (i_exmem_rd),
        .exmem_wen  (i_exmem_wen),
        .exmem_data (i_exmem_data),
        .memwb_rd   (i_memwb_rd),
        .memwb_wen  (i_memwb_wen),
        .memwb_data (i_memwb_data),
        .fwd_data   (fwd_value[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign o_valid      = valid_q;
  assign o_pc         = pc_q;
  assign o_ctrl       = ctrl_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_op1        = ctrl_q[CTRL_OP1_PC]  ? pc_q  : fwd_value[0];
  assign o_op2        = ctrl_q[CTRL_OP2_IMM] ? imm_q : fwd_value[1];
  // Stores take rs2 even though op2 carries the address offset immediate.
  assign o_store_data = fwd_value[1];
  assign o_load_use   = load_use;

endmodule
